// File: rtl/demux4_pkg.sv
// Shared constants and types for the 4-way dispatch demultiplexer.
package demux4_pkg;

  localparam int unsigned NUM_CHAN   = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef logic [1:0] chan_sel_t;

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel FIFO of FIFO_DEPTH words.
// The head is forced to zero while the FIFO is empty.
module demux_chan_fifo
  import demux4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  // A pop on an empty FIFO is dropped, so push+pop at count 0 just pushes.
  assign w_pop  = pop && !empty;
  assign head   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/demux4_dispatch.sv
// One-input, four-output dispatcher with a 2-entry FIFO per channel.
// Define DEMUX4_DISPATCH_COUNT_EN to add the per-channel delivered_cnt counters.
module demux4_dispatch
  import demux4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_sel,
  input  logic [WIDTH-1:0]    in_data,
  output logic [NUM_CHAN-1:0] out_valid,
  input  logic [NUM_CHAN-1:0] out_ready,
  output logic [WIDTH-1:0]    out_data0,
  output logic [WIDTH-1:0]    out_data1,
  output logic [WIDTH-1:0]    out_data2,
  output logic [WIDTH-1:0]    out_data3,
  output logic                idle
`ifdef DEMUX4_DISPATCH_COUNT_EN
  ,
  output logic [31:0]         delivered_cnt
`endif
);

  logic [NUM_CHAN-1:0] w_full;
  logic [NUM_CHAN-1:0] w_empty;
  logic [WIDTH-1:0]    w_head [NUM_CHAN];

  for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
    demux_chan_fifo #(.WIDTH(WIDTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid && (in_sel == chan_sel_t'(k))),
      .pop   (out_ready[k]),
      .wdata (in_data),
      .full  (w_full[k]),
      .empty (w_empty[k]),
      .head  (w_head[k])
    );
  end

  // Depends only on FIFO state and in_sel, never on out_ready.
  assign in_ready  = !w_full[in_sel];
  assign out_valid = ~w_empty;
  assign idle      = &w_empty;
  assign out_data0 = w_head[0];
  assign out_data1 = w_head[1];
  assign out_data2 = w_head[2];
  assign out_data3 = w_head[3];

`ifdef DEMUX4_DISPATCH_COUNT_EN
  logic [7:0]          r_dcnt [NUM_CHAN];
  logic [NUM_CHAN-1:0] w_pop;

  assign w_pop = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CHAN; i++) r_dcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CHAN; i++)
        if (w_pop[i]) r_dcnt[i] <= r_dcnt[i] + 8'd1;
    end
  end

  assign delivered_cnt = {r_dcnt[3], r_dcnt[2], r_dcnt[1], r_dcnt[0]};
`endif

endmodule

// File: tb/tb_demux4_dispatch.sv
// Randomized plus directed bench for demux4_dispatch against a queue-based reference model.
module tb_demux4_dispatch;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic             idle;
`ifdef DEMUX4_DISPATCH_COUNT_EN
  logic [31:0]      delivered_cnt;
`endif

  demux4_dispatch #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .idle      (idle)
`ifdef DEMUX4_DISPATCH_COUNT_EN
    ,
    .delivered_cnt (delivered_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: one queue per channel plus per-channel delivery counts.
  logic [31:0] mq [4][$];
  int          mcnt [4];
  int          npop1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mcnt[k] = 0;
    end
  endtask

  task automatic compare_model();
    logic [3:0]  ev;
    logic [31:0] obs_d [4];
    logic [31:0] exp_d;
    obs_d = '{out_data0, out_data1, out_data2, out_data3};
    for (int k = 0; k < 4; k++) begin
      ev[k] = (mq[k].size() != 0);
      exp_d = ev[k] ? mq[k][0] : 32'd0;
      check($sformatf("out_data%0d", k), obs_d[k], exp_d);
    end
    check("out_valid", {28'd0, out_valid}, {28'd0, ev});
    check("idle", {31'd0, idle}, {31'd0, ev == 4'b0000});
    check("in_ready", {31'd0, in_ready}, {31'd0, mq[in_sel].size() < 2});
`ifdef DEMUX4_DISPATCH_COUNT_EN
    check("delivered_cnt", delivered_cnt,
          {mcnt[3][7:0], mcnt[2][7:0], mcnt[1][7:0], mcnt[0][7:0]});
`endif
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [31:0] d,
                       input logic [3:0] r, output logic acc);
    logic [3:0] pop;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
    compare_model();
    acc = v && (mq[s].size() < 2);
    for (int k = 0; k < 4; k++) pop[k] = r[k] && (mq[k].size() > 0);
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      if (pop[k]) begin
        void'(mq[k].pop_front());
        mcnt[k] = (mcnt[k] + 1) % 256;
        if (k == 1) npop1++;
      end
    if (acc) mq[s].push_back(d);
    @(negedge clk);
  endtask

  task automatic drain();
    logic acc;
    repeat (4) cycle(1'b0, 2'd0, 32'd0, 4'b1111, acc);
  endtask

  initial begin
    logic acc;
    int   start1, start_oth;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'b0000;
    model_reset();
    #1;
    check("rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_data3", out_data3, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of traffic: ch0 full, then asynchronous clear.
    cycle(1'b1, 2'd0, 32'd1, 4'b0000, acc);
    cycle(1'b1, 2'd0, 32'd2, 4'b0000, acc);
    check("pre_rst_ready", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("mid_rst_idle", {31'd0, idle}, 32'd1);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_data0", out_data0, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Routing, latency 1.
    cycle(1'b1, 2'd0, 32'd50, 4'b1111, acc);
    check("route0_valid", {28'd0, out_valid}, 32'b0001);
    check("route0_data", out_data0, 32'd50);
    cycle(1'b1, 2'd1, 32'd10, 4'b1111, acc);
    check("route1_valid", {28'd0, out_valid}, 32'b0010);
    check("route1_data", out_data1, 32'd10);
    cycle(1'b1, 2'd3, 32'd128, 4'b1111, acc);
    check("route3_valid", {28'd0, out_valid}, 32'b1000);
    check("route3_data", out_data3, 32'd128);
    cycle(1'b1, 2'd2, 32'd998, 4'b1111, acc);
    check("route2_valid", {28'd0, out_valid}, 32'b0100);
    check("route2_data", out_data2, 32'd998);
    drain();

    // Back-pressure on ch1.
    cycle(1'b1, 2'd1, 32'd10, 4'b1101, acc);
    cycle(1'b1, 2'd1, 32'd11, 4'b1101, acc);
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check("bp_head", out_data1, 32'd10);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++)
      cycle(1'b1, 2'd1, 32'd12, (i < 2) ? 4'b1101 : 4'b1111, acc);
    check("bp_accept", {31'd0, acc}, 32'd1);
    drain();

    // Simultaneous push and pop on ch2 at count 1.
    cycle(1'b1, 2'd2, 32'd128, 4'b1111, acc);
    cycle(1'b1, 2'd2, 32'd998, 4'b1111, acc);
    check("pp_valid", {28'd0, out_valid}, 32'b0100);
    check("pp_head", out_data2, 32'd998);
    cycle(1'b0, 2'd2, 32'd0, 4'b1111, acc);
    check("pp_count1", {28'd0, out_valid}, 32'b0000);

    // Head-of-line independence: ch3 full must not block ch0.
    cycle(1'b1, 2'd3, 32'd5, 4'b0000, acc);
    cycle(1'b1, 2'd3, 32'd6, 4'b0000, acc);
    in_sel = 2'd0;
    #1;
    check("hol_ready", {31'd0, in_ready}, 32'd1);
    cycle(1'b1, 2'd0, 32'd77, 4'b0000, acc);
    check("hol_valid", {28'd0, out_valid}, 32'b1001);
    check("hol_data0", out_data0, 32'd77);
    drain();

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
            4'($urandom), acc);
    drain();

`ifdef DEMUX4_DISPATCH_COUNT_EN
    start1    = mcnt[1];
    start_oth = mcnt[0] + 256 * mcnt[2] + 65536 * mcnt[3];
    npop1     = 0;
    for (int i = 0; i < 600 && npop1 < 256; i++)
      cycle(1'b1, 2'd1, 32'(i), 4'b0010, acc);
    check("wrap_pops", 32'(npop1), 32'd256);
    check("wrap_field1", {24'd0, delivered_cnt[15:8]}, 32'(start1));
    check("wrap_others", {8'd0, delivered_cnt[31:24], delivered_cnt[23:16], delivered_cnt[7:0]},
          32'(start_oth));
`else
    start1    = 0;
    start_oth = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
